// File: rtl/acc_serializer.sv
// Serializes a captured accumulator sum LSB first, then one even-parity bit,
// framed by a strobe and followed by a one-cycle done pulse.
module acc_serializer #(
  parameter int WIDTH = 44,
  parameter int CNT_W = 6
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] data_in,
  output logic             ready,
  output logic             serial_out,
  output logic             frame,
  output logic             done
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SHIFT  = 2'd1,
    S_PARITY = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  state_t           r_state;
  logic [WIDTH-1:0] r_shift;
  logic [CNT_W-1:0] r_cnt;
  logic             r_par;
  logic             r_ready;
  logic             r_serial;
  logic             r_frame;
  logic             r_done;
  logic             w_accept;

  function automatic logic f_par_step(input logic acc, input logic bit_in);
    return acc ^ bit_in;
  endfunction

  assign w_accept   = r_ready & load;
  assign ready      = r_ready;
  assign serial_out = r_serial;
  assign frame      = r_frame;
  assign done       = r_done;

  // Serializer FSM; the state names the phase currently visible on the outputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_shift  <= {WIDTH{1'b0}};
      r_cnt    <= {CNT_W{1'b0}};
      r_par    <= 1'b0;
      r_ready  <= 1'b1;
      r_serial <= 1'b0;
      r_frame  <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            // Bit 0 goes out on the accepting edge so a frame repeats every WIDTH+3 cycles.
            r_shift  <= data_in >> 1;
            r_cnt    <= {CNT_W{1'b0}};
            r_par    <= data_in[0];
            r_serial <= data_in[0];
            r_frame  <= 1'b1;
            r_ready  <= 1'b0;
            r_done   <= 1'b0;
            r_state  <= S_SHIFT;
          end else begin
            r_ready  <= 1'b1;
            r_serial <= 1'b0;
            r_frame  <= 1'b0;
            r_done   <= 1'b0;
          end
        end
        S_SHIFT: begin
          if (r_cnt == LAST_BIT) begin
            r_serial <= r_par;
            r_state  <= S_PARITY;
          end else begin
            r_serial <= r_shift[0];
            r_par    <= f_par_step(r_par, r_shift[0]);
            r_shift  <= r_shift >> 1;
            r_cnt    <= r_cnt + CNT_W'(1);
          end
        end
        S_PARITY: begin
          r_serial <= 1'b0;
          r_frame  <= 1'b0;
          r_done   <= 1'b1;
          r_state  <= S_DONE;
        end
        S_DONE: begin
          r_done  <= 1'b0;
          r_ready <= 1'b1;
          r_state <= S_IDLE;
        end
        default: begin
          r_state  <= S_IDLE;
          r_ready  <= 1'b1;
          r_serial <= 1'b0;
          r_frame  <= 1'b0;
          r_done   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_acc_serializer.sv
// Scoreboard bench for acc_serializer: stimulus queues expected bits and done
// pulses, a negedge monitor pops and compares whenever the DUT frames output.
module tb_acc_serializer;

  localparam int W = 44;

  logic         clock = 1'b0;
  logic         reset;
  logic         load;
  logic [W-1:0] data_in;
  logic         ready;
  logic         serial_out;
  logic         frame;
  logic         done;

  int n_chk  = 0;
  int n_fail = 0;

  logic exp_q[$];
  int   done_exp  = 0;
  int   frame_len = 0;
  bit   mon_en    = 1'b0;

  acc_serializer #(.WIDTH(W), .CNT_W(6)) dut (
    .clock      (clock),
    .reset      (reset),
    .load       (load),
    .data_in    (data_in),
    .ready      (ready),
    .serial_out (serial_out),
    .frame      (frame),
    .done       (done)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic flag(input string name, input int act, input int exp);
    n_chk++;
    n_fail++;
    $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  // Monitor: pop one expected bit per framed cycle, match done pulses to frames.
  always @(negedge clock) begin
    if (mon_en) begin
      if (frame === 1'b1) begin
        frame_len++;
        if (exp_q.size() == 0) flag("unexpected_frame_bit", 0, 1);
        else check("serial_bit", 64'(serial_out), 64'(exp_q.pop_front()));
      end else if (serial_out !== 1'b0) begin
        check("serial_idle_zero", 64'(serial_out), 64'd0);
      end
      if (done === 1'b1) begin
        check("frame_len", 64'(frame_len), 64'd45);
        frame_len = 0;
        if (done_exp == 0) flag("unexpected_done", 1, 0);
        else begin
          check("done_no_frame", 64'(frame), 64'd0);
          done_exp--;
        end
      end
    end
  end

  // Accept one word; optionally pulse a competing load while bit `hit_bit` is out.
  task automatic send(input logic [W-1:0] d, input logic par, input int hit_bit,
                      input logic [W-1:0] d_hit);
    int cyc;
    for (int i = 0; i < W; i++) exp_q.push_back(d[i]);
    exp_q.push_back(par);
    done_exp++;
    load    = 1'b1;
    data_in = d;
    @(posedge clock); #1;
    load    = 1'b0;
    data_in = 'x;
    check("ready_drop", 64'(ready), 64'd0);
    cyc = 1;
    while (ready !== 1'b1 && cyc < 70) begin
      if (cyc == hit_bit + 1) begin
        load    = 1'b1;
        data_in = d_hit;
      end
      @(posedge clock); #1;
      load = 1'b0;
      cyc++;
    end
    check("ready_return_cycle", 64'(cyc), 64'd47);
  endtask

  initial begin
    reset   = 1'b1;
    load    = 1'b0;
    data_in = '0;
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0;
    check("rst_ready", 64'(ready), 64'd1);
    check("rst_frame", 64'(frame), 64'd0);
    check("rst_serial", 64'(serial_out), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    mon_en = 1'b1;

    data_in = 'x;
    repeat (3) @(posedge clock);
    #1;
    check("idle_x_serial", 64'(serial_out), 64'd0);
    check("idle_x_frame", 64'(frame), 64'd0);

    send(44'd4,               1'b1, -10, '0);
    send(44'h1C,              1'b1, -10, '0);
    send(44'hFFF_FFFF_FFFF,   1'b0, -10, '0);
    send(44'd0,               1'b0, -10, '0);
    send(44'd12,              1'b0,   5, 44'd22);
    repeat (3) @(posedge clock);
    #1;

    // Abort a frame of 28 while bit 10 is on the line.
    for (int i = 0; i < W; i++) exp_q.push_back(1'(44'h1C >> i));
    exp_q.push_back(1'b1);
    load    = 1'b1;
    data_in = 44'h1C;
    @(posedge clock); #1;
    load = 1'b0;
    repeat (10) @(posedge clock);
    #1;
    check("abort_pre_frame", 64'(frame), 64'd1);
    reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    exp_q.delete();
    frame_len = 0;
    check("abort_frame", 64'(frame), 64'd0);
    check("abort_serial", 64'(serial_out), 64'd0);
    check("abort_ready", 64'(ready), 64'd1);
    check("abort_done", 64'(done), 64'd0);
    repeat (50) @(posedge clock);
    #1;

    send(44'd4, 1'b1, -10, '0);
    repeat (3) @(posedge clock);
    #1;
    check("queue_drained", 64'(exp_q.size()), 64'd0);
    check("all_done_seen", 64'(done_exp), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
